baseband_capture: RTL and testbench

Capture buffer on the receive side of the down-conversion chain. It consumes the strobed, decimated baseband X/Y stream (16-bit samples qualified by the downsampler's `ce_out`), optionally decimates it further, and stores a programmed number of sample pairs in an on-chip circular buffer. The SoC CPU drains the buffer through a read-request handshake. It is the reader for the sample stream that the downsampler filters write.

---
 rtl/baseband_capture_pkg.sv | 19 +
 rtl/baseband_capture_sdp_ram.sv | 32 +++
 rtl/baseband_capture.sv | 137 +++++++++++++
 tb/tb_baseband_capture.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baseband_capture_pkg.sv
// Shared types and default widths for the baseband capture buffer.
// Imported by the capture top level and its RAM.
package baseband_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 10;

  // Each stored pair is {x, y} with X in the upper half.
  localparam int PAIR_W = 2 * DW_DEF;
  localparam int X_LSB  = DW_DEF;
  localparam int Y_LSB  = 0;

endpackage

// File: rtl/baseband_capture_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the output register is reset; the array stays BRAM-friendly.
module sdp_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output holds the last popped pair until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/baseband_capture.sv
// Decimating capture of the strobed X/Y baseband stream into a
// circular buffer, drained by the CPU through rd_req pops.
module baseband_capture
  import baseband_capture_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_x,
  input  logic [DW-1:0]   s_y,
  input  logic            arm,
  input  logic            abort,
  input  logic [AW:0]     capture_len,
  input  logic [7:0]      decim,
  input  logic            rd_req,
  output logic [2*DW-1:0] rd_data,
  output logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic            underflow,
  output logic [AW:0]     level
);

  localparam logic [AW:0] FULL = (AW+1)'(1) << AW;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [AW:0]   stored_q, stored_d;
  logic [AW:0]   len_q, len_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic [7:0]    decim_q, decim_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rv_q;

  logic strobe, take, wr, pop;

  // arm overrides everything else in the cycle, including a pop.
  assign strobe = s_valid & (state_q == CAPTURE) & ~arm & ~abort;
  assign take   = strobe & (dcnt_q == 8'd0);
  assign wr     = take & (level_q != FULL);
  assign pop    = rd_req & ~arm & (level_q != '0);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    level_d  = level_q;
    stored_d = stored_q;
    len_d    = len_q;
    dcnt_d   = dcnt_q;
    decim_d  = decim_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (arm) begin
      wptr_d   = '0;
      rptr_d   = '0;
      level_d  = '0;
      stored_d = '0;
      dcnt_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      len_d    = capture_len;
      decim_d  = decim;
      state_d  = (capture_len == '0) ? DONE : CAPTURE;
    end else begin
      if (strobe)
        dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
      if (take && !wr) ovf_d = 1'b1;
      if (wr) begin
        wptr_d   = wptr_q + 1'b1;
        stored_d = stored_q + 1'b1;
        if (stored_d == len_q) state_d = DONE;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      if (rd_req && level_q == '0) unf_d = 1'b1;
      level_d = level_q + (AW+1)'(wr) - (AW+1)'(pop);
      if (abort && state_q != IDLE) state_d = IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      stored_q <= '0;
      len_q    <= '0;
      dcnt_q   <= '0;
      decim_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      stored_q <= stored_d;
      len_q    <= len_d;
      dcnt_q   <= dcnt_d;
      decim_q  <= decim_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rv_q     <= pop;
    end
  end

  sdp_ram #(
    .DW(2*DW),
    .AW(AW)
  ) u_ram (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .we   (wr),
    .waddr(wptr_q),
    .wdata({s_x, s_y}),
    .re   (pop),
    .raddr(rptr_q),
    .rdata(rd_data)
  );

  assign rd_valid  = rv_q;
  assign busy      = (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign level     = level_q;

endmodule

// File: tb/tb_baseband_capture.sv
// Directed and random stimulus for baseband_capture against a
// queue-based reference model; a second depth-8 instance covers overflow.
module tb_baseband_capture;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst_n, s_valid, arm, abort, rd_req;
  logic [15:0] s_x, s_y;
  logic [10:0] capture_len;
  logic [3:0]  clb;
  logic [7:0]  decim;

  logic [31:0] rd_data;
  logic        rd_valid, busy, done, overflow, underflow;
  logic [10:0] level;

  logic [31:0] b_rd_data;
  logic        b_rd_valid, b_busy, b_done, b_overflow, b_underflow;
  logic [3:0]  b_level;

  baseband_capture #(.DW(16), .AW(10)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .s_valid(s_valid),
    .s_x(s_x), .s_y(s_y), .arm(arm), .abort(abort),
    .capture_len(capture_len), .decim(decim), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .overflow(overflow), .underflow(underflow),
    .level(level)
  );

  baseband_capture #(.DW(16), .AW(3)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .s_valid(s_valid),
    .s_x(s_x), .s_y(s_y), .arm(arm), .abort(abort),
    .capture_len(clb), .decim(decim), .rd_req(rd_req),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy),
    .done(b_done), .overflow(b_overflow), .underflow(b_underflow),
    .level(b_level)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] mq[$];
  int          mst, mstored, mdc, mlen, mdec;
  bit          movf, munf, mrv;
  logic [31:0] mrd;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst = 0; mstored = 0; mdc = 0; mlen = 0; mdec = 0;
    movf = 0; munf = 0; mrv = 0; mrd = '0;
  endtask

  // mst: 0 idle, 1 capturing, 2 done
  task automatic model_step();
    bit full, acc;
    full = (mq.size() == 1024);
    if (arm) begin
      mq.delete();
      mstored = 0; mdc = 0; movf = 0; munf = 0; mrv = 0;
      mlen = int'(capture_len);
      mdec = int'(decim);
      mst  = (mlen == 0) ? 2 : 1;
    end else begin
      mrv = 0;
      if (rd_req) begin
        if (mq.size() > 0) begin
          mrd = mq.pop_front();
          mrv = 1;
        end else munf = 1;
      end
      if (abort && mst != 0) mst = 0;
      else if (mst == 1 && s_valid) begin
        acc = (mdc == 0);
        mdc = (mdc == mdec) ? 0 : mdc + 1;
        if (acc) begin
          if (full) movf = 1;
          else begin
            mq.push_back({s_x, s_y});
            mstored++;
            if (mstored == mlen) mst = 2;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("level", 64'(level), 64'(mq.size()));
    chk("busy", 64'(busy), 64'(mst == 1));
    chk("done", 64'(done), 64'(mst == 2));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("underflow", 64'(underflow), 64'(munf));
    chk("rd_valid", 64'(rd_valid), 64'(mrv));
    chk("rd_data", 64'(rd_data), 64'(mrd));
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    model_step();
    #1;
    check_all();
    arm = 0; abort = 0; rd_req = 0; s_valid = 0;
  endtask

  task automatic strobe(int n);
    s_valid = 1;
    s_x = 16'(n);
    s_y = 16'(0 - n);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 0; s_valid = 0; arm = 0; abort = 0; rd_req = 0;
    s_x = '0; s_y = '0; capture_len = '0; decim = '0; clb = 4'd12;
    model_reset();
    #12;
    check_all();
    chk("b_level_rst", 64'(b_level), 64'd0);
    rst_n = 1;

    // 8 pairs, decim 0, strobe every 4th cycle
    arm = 1; capture_len = 11'd8; decim = 8'd0;
    cyc();
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) strobe(i / 4);
      cyc();
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_level", 64'(level), 64'd8);
    for (int k = 0; k < 8; k++) begin
      rd_req = 1;
      cyc();
      w = {16'(k), 16'(0 - k)};
      chk("t1_pop", 64'(rd_data), 64'(w));
    end
    cyc();
    chk("t1_rv_pulse", 64'(rd_valid), 64'd0);
    chk("t1_empty", 64'(level), 64'd0);

    // decim 2: keep every third strobe
    arm = 1; capture_len = 11'd4; decim = 8'd2;
    cyc();
    for (int i = 0; i < 12; i++) begin
      strobe(i);
      cyc();
      cyc();
    end
    chk("t2_done", 64'(done), 64'd1);
    for (int k = 0; k < 4; k++) begin
      rd_req = 1;
      cyc();
      chk("t2_x", 64'(rd_data[31:16]), 64'(3 * k));
    end

    // depth-8 instance: overflow, then drain and finish the count
    arm = 1; capture_len = 11'd12; decim = 8'd0; clb = 4'd12;
    cyc();
    for (int i = 0; i < 12; i++) begin
      strobe(i);
      cyc();
    end
    chk("b_level_full", 64'(b_level), 64'd8);
    chk("b_overflow", 64'(b_overflow), 64'd1);
    chk("b_busy", 64'(b_busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      rd_req = 1;
      cyc();
      chk("b_rv", 64'(b_rd_valid), 64'd1);
      chk("b_pop_x", 64'(b_rd_data[31:16]), 64'(k));
    end
    chk("b_level_drain", 64'(b_level), 64'd4);
    chk("b_still_busy", 64'(b_busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      strobe(100 + i);
      cyc();
    end
    chk("b_done", 64'(b_done), 64'd1);
    chk("b_level_end", 64'(b_level), 64'd8);
    chk("b_underflow", 64'(b_underflow), 64'd0);

    // streaming with a pop every cycle
    arm = 1; capture_len = 11'd16; decim = 8'd0;
    cyc();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        s_valid = 1;
        s_x = 16'($urandom);
        s_y = 16'($urandom);
      end
      if (i > 0) rd_req = 1;
      cyc();
      chk("t4_lvl_le1", 64'(level <= 11'd1), 64'd1);
    end
    chk("t4_done", 64'(done), 64'd1);

    // underflow, then re-arm mid-capture
    rd_req = 1;
    cyc();
    chk("t5_unf", 64'(underflow), 64'd1);
    chk("t5_rv", 64'(rd_valid), 64'd0);
    arm = 1; capture_len = 11'd20;
    cyc();
    for (int i = 0; i < 5; i++) begin
      strobe(40 + i);
      cyc();
    end
    arm = 1; rd_req = 1;
    cyc();
    chk("t5_rearm_lvl", 64'(level), 64'd0);
    chk("t5_rearm_unf", 64'(underflow), 64'd0);
    chk("t5_rearm_rv", 64'(rd_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      strobe(60 + i);
      cyc();
    end
    chk("t5_restart", 64'(level), 64'd3);

    // zero length goes straight to DONE
    arm = 1; capture_len = 11'd0;
    cyc();
    strobe(7);
    cyc();
    chk("t5_len0_done", 64'(done), 64'd1);
    chk("t5_len0_lvl", 64'(level), 64'd0);

    // async reset mid-capture
    arm = 1; capture_len = 11'd30;
    cyc();
    for (int i = 0; i < 3; i++) begin
      strobe(85 + i);
      cyc();
    end
    rd_req = 1;
    cyc();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_b_level", 64'(b_level), 64'd0);
    @(posedge sys_clk);
    #3;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      strobe(90 + i);
      cyc();
    end
    chk("post_rst_lvl", 64'(level), 64'd0);
    chk("post_rst_idle", 64'(busy), 64'd0);

    // random traffic against the model
    arm = 1; capture_len = 11'd25; decim = 8'd1;
    cyc();
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_x = 16'($urandom);
      s_y = 16'($urandom);
      rd_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 40) == 0) begin
        arm = 1;
        capture_len = 11'($urandom_range(0, 30));
        decim = 8'($urandom_range(0, 2));
      end
      abort = ($urandom_range(0, 60) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
